// File: rtl/param_fifo.sv
// Synchronous FIFO with a power-of-two depth.
// Supports a registered-read mode and a first-word-fall-through mode, registered
// full/empty/threshold flags, an occupancy count, and sticky overflow/underflow flags.
module param_fifo #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4,
    parameter bit          FWFT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] head_d;

    // Next-state: acceptance, pointers, count, flags, error flags and read data
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_W'(AF_LEVEL));
        ae_d    = (count_d <= CNT_W'(AE_LEVEL));

        // Set condition takes priority over the clear
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr_en && full_q)  ovf_d = 1'b1;
        if (rd_en && empty_q) unf_d = 1'b1;

        // Word at the head after this edge; bypass din when it lands in that slot now
        head_d = (wr_acc && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];

        if (FWFT) begin
            dv_d = !empty_d;
            if (!empty_d) dout_d = head_d;
        end else begin
            dv_d = rd_acc;
            if (rd_acc) dout_d = mem_q[rd_ptr_q];
        end
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_ptr_q] <= din;
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dv_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: two instances (registered read and FWFT) share stimulus
// and are compared against a queue-based reference model plus directed tables.
module tb_param_fifo;

    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en, clr_err;
    logic [15:0] din;

    logic [15:0] dout0, dout1;
    logic        dv0, dv1, full0, full1, empty0, empty1;
    logic        af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [3:0]  count0, count1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    param_fifo #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
        .dout(dout0), .dout_valid(dv0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0));

    param_fifo #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
        .dout(dout1), .dout_valid(dv1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1));

    // Reference model state
    logic [15:0] mq[$];
    logic        m_ovf, m_unf, m_dv0, m_d1k;
    logic [15:0] m_dout0, m_dout1;

    typedef struct {
        logic        wr;
        logic [15:0] din;
        logic        rd;
        logic [3:0]  cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ovf;
        logic        unf;
        logic        dv;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Queue-level behaviour of a depth-8 FIFO for one clock edge
    task automatic model_update();
        int sz;
        sz = mq.size();
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
            m_dout0 = '0; m_dv0 = 1'b0;
            m_dout1 = '0; m_d1k = 1'b1;
        end else begin
            if (wr_en && sz == 8) m_ovf = 1'b1;
            else if (clr_err)     m_ovf = 1'b0;
            if (rd_en && sz == 0) m_unf = 1'b1;
            else if (clr_err)     m_unf = 1'b0;
            m_dv0 = 1'b0;
            if (rd_en && sz > 0) begin
                m_dout0 = mq.pop_front();
                m_dv0   = 1'b1;
            end
            if (wr_en && sz < 8) mq.push_back(din);
            if (mq.size() > 0) begin
                m_dout1 = mq[0];
                m_d1k   = 1'b1;
            end else if (sz > 0) begin
                m_d1k = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        chk("count0", 32'(count0), 32'(sz));
        chk("count1", 32'(count1), 32'(sz));
        chk("full0",  32'(full0),  32'(sz == 8));
        chk("full1",  32'(full1),  32'(sz == 8));
        chk("empty0", 32'(empty0), 32'(sz == 0));
        chk("empty1", 32'(empty1), 32'(sz == 0));
        chk("af0",    32'(af0),    32'(sz >= 6));
        chk("af1",    32'(af1),    32'(sz >= 6));
        chk("ae0",    32'(ae0),    32'(sz <= 2));
        chk("ae1",    32'(ae1),    32'(sz <= 2));
        chk("ovf0",   32'(ovf0),   32'(m_ovf));
        chk("ovf1",   32'(ovf1),   32'(m_ovf));
        chk("unf0",   32'(unf0),   32'(m_unf));
        chk("unf1",   32'(unf1),   32'(m_unf));
        chk("dv0",    32'(dv0),    32'(m_dv0));
        chk("dout0",  32'(dout0),  32'(m_dout0));
        chk("dv1",    32'(dv1),    32'(sz > 0));
        if (m_d1k) chk("dout1", 32'(dout1), 32'(m_dout1));
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r,
                        input logic c, input logic rs);
        wr_en = w; din = d; rd_en = r; clr_err = c; rst = rs;
        @(posedge clk);
        model_update();
        #1;
        cyc++;
        check_model();
    endtask

    initial begin
        int cnt;
        int pw, pr;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_dv0 = 1'b0; m_d1k = 1'b0;
        m_dout0 = '0; m_dout1 = '0;

        // Fill, overflow, drain, underflow expectations derived by hand
        for (int i = 0; i < 9; i++) begin
            cnt = (i + 1 > 8) ? 8 : i + 1;
            tbl[i] = '{wr: 1'b1, din: 16'(i + 1), rd: 1'b0, cnt: 4'(cnt),
                       full: (cnt == 8), empty: 1'b0, af: (cnt >= 6),
                       ovf: (i == 8), unf: 1'b0, dv: 1'b0, dout: 16'h0000};
        end
        for (int k = 0; k < 8; k++) begin
            tbl[9 + k] = '{wr: 1'b0, din: 16'h0000, rd: 1'b1, cnt: 4'(7 - k),
                           full: 1'b0, empty: (k == 7), af: ((7 - k) >= 6),
                           ovf: 1'b1, unf: 1'b0, dv: 1'b1, dout: 16'(k + 1)};
        end
        tbl[17] = '{wr: 1'b0, din: 16'h0000, rd: 1'b1, cnt: 4'd0, full: 1'b0,
                    empty: 1'b1, af: 1'b0, ovf: 1'b1, unf: 1'b1, dv: 1'b0,
                    dout: 16'h0008};

        // Reset state
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(count0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_ae",    32'(ae0),    32'd1);
        chk("rst_dout1", 32'(dout1),  32'd0);

        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].din, tbl[i].rd, 1'b0, 1'b0);
            chk("tbl_count", 32'(count0), 32'(tbl[i].cnt));
            chk("tbl_full",  32'(full0),  32'(tbl[i].full));
            chk("tbl_empty", 32'(empty0), 32'(tbl[i].empty));
            chk("tbl_af",    32'(af0),    32'(tbl[i].af));
            chk("tbl_ovf",   32'(ovf0),   32'(tbl[i].ovf));
            chk("tbl_unf",   32'(unf0),   32'(tbl[i].unf));
            chk("tbl_dv",    32'(dv0),    32'(tbl[i].dv));
            chk("tbl_dout",  32'(dout0),  32'(tbl[i].dout));
        end

        // Clear both sticky flags
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(ovf0), 32'd0);
        chk("clr_unf", 32'(unf0), 32'd0);

        // Simultaneous read/write at count 3 across pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(16'h0103 + i), 1'b1, 1'b0, 1'b0);
            chk("wrap_count", 32'(count0), 32'd3);
            chk("wrap_dout",  32'(dout0),  32'(16'h0100 + i));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            chk("wrap_tail", 32'(dout0), 32'(16'h0114 + i));
        end

        // Overflow wins over a concurrent clear, then a lone clear drops it
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0);
        chk("clr_vs_set", 32'(ovf0), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("clr_after", 32'(ovf0), 32'd0);

        // Reset mid-operation at count 5 with overflow set
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count0), 32'd5);
        chk("pre_rst_ovf",   32'(ovf0),   32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_count", 32'(count0), 32'd0);
        chk("mid_rst_empty", 32'(empty0), 32'd1);
        chk("mid_rst_ae",    32'(ae0),    32'd1);
        chk("mid_rst_ovf",   32'(ovf0),   32'd0);
        chk("mid_rst_dout",  32'(dout0),  32'd0);
        step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_dout", 32'(dout0), 32'h5A5A);
        chk("post_rst_dv",   32'(dv0),   32'd1);

        // First-word fall-through into an empty FIFO
        step(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0);
        chk("fwft_dout", 32'(dout1), 32'hABCD);
        chk("fwft_dv",   32'(dv1),   32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("fwft_empty", 32'(empty1), 32'd1);
        chk("fwft_dv_lo", 32'(dv1),    32'd0);

        // Random traffic with shifting bias to visit full and empty repeatedly
        for (int i = 0; i < 3000; i++) begin
            case ((i / 150) % 3)
                0:       begin pw = 85; pr = 20; end
                1:       begin pw = 20; pr = 85; end
                default: begin pw = 50; pr = 50; end
            endcase
            step(($urandom_range(0, 99) < pw), 16'($urandom()),
                 ($urandom_range(0, 99) < pr), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 499) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 32: storage depth in words, a power of 2, at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4: almost-full threshold in words, 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 4: almost-empty threshold in words, 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0: 0 selects registered-read mode, 1 selects first-word-fall-through mode.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port wr_en, input, 1 bit: write request.
REQ-009 Port din, input, WIDTH bits: write data.
REQ-010 Port rd_en, input, 1 bit: read request (in FWFT mode, acknowledges the head word).
REQ-011 Port dout, output, WIDTH bits: read data.
REQ-012 Port dout_valid, output, 1 bit: dout holds valid read data.
REQ-013 Port full / empty, outputs, 1 bit each: occupancy equals DEPTH / 0.
REQ-014 Port almost_full / almost_empty, outputs, 1 bit each: threshold flags.
REQ-015 Port count, output, clog2(DEPTH)+1 bits: number of stored words, 0..DEPTH.
REQ-016 Port overflow / underflow, outputs, 1 bit each: sticky error flags.
REQ-017 Port clr_err, input, 1 bit: clears overflow and underflow.

Function
REQ-018 A write is accepted when wr_en=1 and full=0; din is stored at the write pointer.
REQ-019 A read is accepted when rd_en=1 and empty=0; the read pointer advances.
REQ-020 Full and empty gate acceptance; no write is accepted while full, even with a simultaneous accepted read.
REQ-021 Both pointers wrap modulo DEPTH; data order is strictly first-in, first-out across the wrap.
REQ-022 count updates per cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 full, empty, almost_full (count>=AF_LEVEL) and almost_empty (count<=AE_LEVEL) are registered and reflect the post-update count in the same cycle count changes.
REQ-024 FWFT=0 (registered read):
- An accepted read loads dout with the head word on that clock edge.
- dout_valid is 1 for exactly the following cycle.
- dout holds its value otherwise.
REQ-025 FWFT=1 (first-word fall-through):
- dout shows the head word whenever empty=0, and dout_valid equals !empty.
- An accepted read advances dout to the next word on the following cycle.
- A word written into an empty FIFO appears on dout one cycle after the write edge.
REQ-026 overflow sets when wr_en=1 while full=1; underflow sets when rd_en=1 while empty=1.
REQ-027 overflow and underflow clear only on clr_err=1; if a set condition and clr_err coincide, the set condition wins.
REQ-028 A rejected write or read changes no pointer, no count, no stored data and no dout.

Reset
REQ-029 With rst=1 at a clock edge:
- pointers, count, dout, dout_valid, full, almost_full, overflow and underflow become 0;
- empty and almost_empty become 1 (almost_empty because AE_LEVEL>=0).
REQ-030 rst overrides all other inputs in the same cycle; a reset during activity discards all stored words. Memory contents are not reset.

Verification (DEPTH=8, WIDTH=16, AF_LEVEL=6, AE_LEVEL=2 unless noted)
REQ-031 Fill/overflow: write 0x0001..0x0008 on consecutive cycles, then one more write.
- almost_full=1 at count=6; full=1 at count=8.
- The ninth write sets overflow=1; count stays 8.
REQ-032 Drain order (FWFT=0): after the fill, assert rd_en for 8 cycles.
- dout = 0x0001..0x0008 in order, each with dout_valid=1 one cycle after its rd_en.
- empty=1 after the eighth read; a ninth rd_en sets underflow=1.
REQ-033 Simultaneous access and wrap-around:
- at count=3, assert wr_en and rd_en together for 20 cycles with incrementing data;
- count stays 3, and the read data sequence is intact across pointer wrap.
REQ-034 FWFT=1: write 0xABCD into the empty FIFO.
- Next cycle: dout=0xABCD and dout_valid=1 with no rd_en.
- One rd_en: empty=1 and dout_valid=0 the following cycle.
REQ-035 Reset mid-operation: at count=5 with overflow=1, assert rst for one cycle.
- count=0, empty=1, almost_empty=1, overflow=0, dout=0.
- The next write/read pair returns the newly written word.
REQ-036 Error clear: with overflow=1, pulse clr_err.
- overflow=0 next cycle.
- clr_err concurrent with a write while full keeps overflow=1.
